// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// clamp_div() raises small divisors to DIV_MIN; half() gives the high-phase length.
package clkdiv_pkg;

  localparam int DIV_MIN = 2;
  localparam int CW_DEF  = 16;

  function automatic logic [31:0] clamp_div(
    input logic [31:0] d
  );
    return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
  endfunction

  function automatic logic [31:0] half(
    input logic [31:0] d
  );
    return d >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active divisor, phase counter, pending divisor, outputs.
// Ports: clk, rst, en, sync, wr/wr_data (pre-clamped) in; pend, clkout, tick out.
module clk_div_chan
  import clkdiv_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int DEF_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] wr_data,
  output logic          pend,
  output logic          clkout,
  output logic          tick
);

  localparam logic [CW-1:0] DEF_D = CW'(DEF_DIV);
  localparam logic [CW-1:0] DEF_C = CW'(DEF_DIV - 1);

  logic [CW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] p_q, p_d;
  logic          pend_q, pend_d;
  logic          clkout_q, clkout_d;
  logic          tick_q, tick_d;
  logic          wrap;

  // >= rather than == keeps a stray out-of-range count from running away.
  assign wrap = en & (sync | (cnt_q >= d_q - CW'(1)));

  always_comb begin
    d_d    = d_q;
    cnt_d  = cnt_q;
    p_d    = p_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    if (en) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (pend_q) begin
          d_d    = p_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      // A write landing on a wrap is staged after the wrap consumed the old P.
      if (wr) begin
        p_d    = wr_data;
        pend_d = 1'b1;
      end
    end else if (wr) begin
      // Idle channel: apply at once, parked at the end of a low phase.
      d_d    = wr_data;
      cnt_d  = wr_data - CW'(1);
      pend_d = 1'b0;
    end
    clkout_d = cnt_d < CW'(half(32'(d_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q      <= DEF_D;
      cnt_q    <= DEF_C;
      p_q      <= DEF_D;
      pend_q   <= 1'b0;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      pend_q   <= pend_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
    end
  end

  assign pend   = pend_q;
  assign clkout = clkout_q;
  assign tick   = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// NCH-channel programmable clock divider with glitch-free ratio changes.
// Ports: CLKIN, RST, EN, DIV_WR/SEL/DATA in; DIV_ACK, PEND, CLKOUT, TICK out.
// Option CLKDIV_SYNC_EN adds input SYNC to phase-align all enabled channels.
module clk_div_multi
  import clkdiv_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int CW      = CW_DEF,
  parameter  int DEF_DIV = 4,
  localparam int SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLKIN,
  input  logic           RST,
`ifdef CLKDIV_SYNC_EN
  input  logic           SYNC,
`endif
  input  logic [NCH-1:0] EN,
  input  logic           DIV_WR,
  input  logic [SW-1:0]  DIV_SEL,
  input  logic [CW-1:0]  DIV_DATA,
  output logic           DIV_ACK,
  output logic [NCH-1:0] PEND,
  output logic [NCH-1:0] CLKOUT,
  output logic [NCH-1:0] TICK
);

  localparam logic [SW:0] NCH_V = (SW + 1)'(NCH);

  logic          sel_ok;
  logic          sync_w;
  logic [CW-1:0] wr_data;
  logic          ack_q, ack_d;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = SYNC;
`else
  assign sync_w = 1'b0;
`endif

  assign sel_ok  = {1'b0, DIV_SEL} < NCH_V;
  assign wr_data = CW'(clamp_div(32'(DIV_DATA)));

  always_comb begin
    ack_d = DIV_WR & sel_ok;
  end

  always_ff @(posedge CLKIN) begin
    if (RST) ack_q <= 1'b0;
    else     ack_q <= ack_d;
  end

  assign DIV_ACK = ack_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic wr_g;
    assign wr_g = DIV_WR & sel_ok & (DIV_SEL == SW'(g));

    clk_div_chan #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (CLKIN),
      .rst     (RST),
      .en      (EN[g]),
      .sync    (sync_w),
      .wr      (wr_g),
      .wr_data (wr_data),
      .pend    (PEND[g]),
      .clkout  (CLKOUT[g]),
      .tick    (TICK[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized bench for clk_div_multi against a per-channel phase model.
// Five channels so an out-of-range DIV_SEL is reachable.
module tb_clk_div_multi;

  localparam int NCH = 5;
  localparam int CW  = 16;
  localparam int DEF = 4;
  localparam int SW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           sync_i;
  logic [NCH-1:0] en;
  logic           wr;
  logic [SW-1:0]  sel;
  logic [CW-1:0]  data;
  logic           ack;
  logic [NCH-1:0] pend, clkout, tick;

  always #5 clk = ~clk;

  clk_div_multi #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF)) dut (
    .CLKIN    (clk),
    .RST      (rst),
`ifdef CLKDIV_SYNC_EN
    .SYNC     (sync_i),
`endif
    .EN       (en),
    .DIV_WR   (wr),
    .DIV_SEL  (sel),
    .DIV_DATA (data),
    .DIV_ACK  (ack),
    .PEND     (pend),
    .CLKOUT   (clkout),
    .TICK     (tick)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: divisor, position within the period, staged divisor.
  int             md[NCH];
  int             mpos[NCH];
  int             mp[NCH];
  bit             mpend[NCH];
  logic [NCH-1:0] e_clk, e_tick, e_pend;
  logic           e_ack;

  bit p_clk[4]  = '{1, 1, 0, 0};
  bit p_tick[4] = '{1, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [NCH-1:0] e,
                            input logic w, input int s, input int dv,
                            input logic sy);
    int  nd;
    bit  start;
    nd = (dv < 2) ? 2 : dv;
    for (int i = 0; i < NCH; i++) begin
      e_tick[i] = 1'b0;
      if (r) begin
        md[i] = DEF; mpos[i] = DEF - 1; mpend[i] = 0;
      end else if (e[i]) begin
        start = sy || (mpos[i] == md[i] - 1);
        if (start) begin
          mpos[i] = 0;
          e_tick[i] = 1'b1;
          if (mpend[i]) begin md[i] = mp[i]; mpend[i] = 0; end
        end else begin
          mpos[i] = mpos[i] + 1;
        end
        if (w && s == i) begin mp[i] = nd; mpend[i] = 1; end
      end else if (w && s == i) begin
        md[i] = nd; mpos[i] = nd - 1; mpend[i] = 0;
      end
      e_clk[i]  = (mpos[i] < md[i] / 2);
      e_pend[i] = mpend[i];
    end
    e_ack = !r && w && (s < NCH);
  endtask

  task automatic cyc(input logic r, input logic [NCH-1:0] e,
                     input logic w, input int s, input int dv,
                     input logic sy);
    @(negedge clk);
    rst = r; en = e; wr = w; sel = SW'(s); data = CW'(dv); sync_i = sy;
`ifndef CLKDIV_SYNC_EN
    model_step(r, e, w, s, dv, 1'b0);
`else
    model_step(r, e, w, s, dv, sy);
`endif
    @(posedge clk);
    #1;
    chk("clkout", 32'(clkout), 32'(e_clk));
    chk("tick",   32'(tick),   32'(e_tick));
    chk("pend",   32'(pend),   32'(e_pend));
    chk("ack",    32'(ack),    32'(e_ack));
  endtask

  task automatic idle(input logic [NCH-1:0] e, input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, e, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; en = '0; wr = 1'b0; sel = '0; data = '0; sync_i = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      md[i] = DEF; mpos[i] = DEF - 1; mp[i] = DEF; mpend[i] = 0;
    end

    cyc(1'b1, '0, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, '0, 1'b0, 0, 0, 1'b0);
    chk("rst_clk", 32'(clkout), 0);
    chk("rst_pend", 32'(pend), 0);

    // Default divide-by-4 on channel 0.
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 5'b00001, 1'b0, 0, 0, 1'b0);
      chk("t1_clk", 32'(clkout[0]), 32'(p_clk[k % 4]));
      chk("t1_tick", 32'(tick[0]), 32'(p_tick[k % 4]));
    end

    // Channel 1 retargeted to 5 mid-period.
    idle(5'b00011, 2);
    cyc(1'b0, 5'b00011, 1'b1, 1, 5, 1'b0);
    chk("t2_ack", 32'(ack), 1);
    chk("t2_pend", 32'(pend[1]), 1);
    idle(5'b00011, 14);

    // Divisor 0 clamps to 2.
    cyc(1'b0, 5'b00111, 1'b1, 2, 0, 1'b0);
    idle(5'b00111, 10);

    // Freeze channel 0 at position 1 and reprogram it while idle.
    guard = 0;
    while (mpos[0] != 1 && guard < 20) begin
      idle(5'b00111, 1);
      guard++;
    end
    chk("t4_phase_found", 32'(guard < 20), 1);
    idle(5'b00110, 3);
    cyc(1'b0, 5'b00110, 1'b1, 0, 6, 1'b0);
    chk("t4_pend", 32'(pend[0]), 0);
    chk("t4_clk", 32'(clkout[0]), 0);
    cyc(1'b0, 5'b00111, 1'b0, 0, 0, 1'b0);
    chk("t4_rise", 32'(clkout[0]), 1);
    chk("t4_tick", 32'(tick[0]), 1);
    idle(5'b00111, 12);

    // Out-of-range select, then a write coincident with a wrap.
    cyc(1'b0, 5'b00111, 1'b1, NCH, 7, 1'b0);
    chk("t5_noack", 32'(ack), 0);
    guard = 0;
    while (mpos[1] != md[1] - 1 && guard < 20) begin
      idle(5'b00111, 1);
      guard++;
    end
    chk("t5_phase_found", 32'(guard < 20), 1);
    cyc(1'b0, 5'b00111, 1'b1, 1, 3, 1'b0);
    chk("t5_tick", 32'(tick[1]), 1);
    chk("t5_pend", 32'(pend[1]), 1);
    idle(5'b00111, 14);

`ifdef CLKDIV_SYNC_EN
    cyc(1'b0, 5'b00111, 1'b1, 0, 4, 1'b0);
    cyc(1'b0, 5'b00111, 1'b1, 1, 6, 1'b0);
    idle(5'b00111, 9);
    cyc(1'b0, 5'b00111, 1'b0, 0, 0, 1'b1);
    chk("t6_sync_clk", 32'(clkout[1:0]), 3);
    chk("t6_sync_tick", 32'(tick[1:0]), 3);
    idle(5'b00111, 8);
`endif

    // Reset mid-period with a divisor pending.
    cyc(1'b0, 5'b00111, 1'b1, 2, 7, 1'b0);
    cyc(1'b1, 5'b00111, 1'b0, 0, 0, 1'b0);
    chk("rst2_clk", 32'(clkout), 0);
    chk("rst2_pend", 32'(pend), 0);
    chk("rst2_tick", 32'(tick), 0);
    idle(5'b11111, 5);

    for (int k = 0; k < 3000; k++) begin
      logic [NCH-1:0] e;
      e = (($urandom_range(0, 15) == 0)) ? NCH'($urandom) : en;
      cyc(($urandom_range(0, 299) == 0),
          e,
          ($urandom_range(0, 4) == 0),
          int'($urandom_range(0, 7)),
          int'($urandom_range(0, 9)),
          ($urandom_range(0, 24) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
